// File: rtl/video_src_pkg.sv
// Shared types for the parallel-video pattern source: FSM states, pattern codes
// and the per-frame geometry snapshot.
package video_src_pkg;

    // Shadow geometry fields are sized for the widest counter the source supports.
    localparam int GEO_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE,
        ACT,
        HBLK,
        VBLK
    } state_t;

    localparam logic [1:0] PAT_HRAMP = 2'd0;
    localparam logic [1:0] PAT_VRAMP = 2'd1;
    localparam logic [1:0] PAT_CHECK = 2'd2;
    localparam logic [1:0] PAT_FRAME = 2'd3;

    typedef struct packed {
        logic [GEO_WIDTH-1:0] x_active;
        logic [GEO_WIDTH-1:0] x_blank;
        logic [GEO_WIDTH-1:0] y_active;
        logic [GEO_WIDTH-1:0] y_blank;
        logic [1:0]           pattern;
    } geo_t;

    // A zero-length line, blanking interval or frame height cannot be generated.
    function automatic logic geo_ok(input geo_t g);
        return (g.x_active != '0) && (g.x_blank != '0) && (g.y_active != '0);
    endfunction

endpackage

// File: rtl/video_pattern_src_if.sv
// Parallel-video bus (pixel data plus de/hs/vs) between a source and its consumer.
interface video_pattern_src_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] do_o;
    logic                  de_o;
    logic                  hs_o;
    logic                  vs_o;

    modport master (output do_o, de_o, hs_o, vs_o);
    modport slave  (input  do_o, de_o, hs_o, vs_o);
endinterface

// File: rtl/video_pattern_px.sv
// Pixel generator: turns the current x/y/frame position into a registered pixel
// that lines up with the registered de/hs/vs of the source.
module video_pattern_px
    import video_src_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  active,
    input  logic [CNT_WIDTH-1:0]  x,
    input  logic [CNT_WIDTH-1:0]  y,
    input  logic [7:0]            frcnt,
    input  logic [1:0]            pattern,
    output logic [DATA_WIDTH-1:0] pixel
);
    localparam int W = (DATA_WIDTH > CNT_WIDTH + 1) ? DATA_WIDTH : CNT_WIDTH + 1;

    logic [W-1:0] wide;
    logic [W-1:0] unused_wide;

    // Patterns are formed wide enough to hold x+frcnt, then cut to the bus width.
    always_comb begin
        wide = '0;
        case (pattern)
            PAT_HRAMP: wide = W'(x);
            PAT_VRAMP: wide = W'(y);
            PAT_CHECK: wide = (x[3] ^ y[3]) ? '1 : '0;
            PAT_FRAME: wide = W'(x) + W'(frcnt);
            default:   wide = '0;
        endcase
    end

    assign unused_wide = wide;

    // Blanking cycles always carry a zero pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            pixel <= '0;
        end else begin
            pixel <= active ? wide[DATA_WIDTH-1:0] : '0;
        end
    end

endmodule

// File: rtl/video_pattern_src.sv
// Parallel-video test source: frame timing FSM with per-frame geometry latching
// and registered de/hs/vs/pixel outputs.
module video_pattern_src
    import video_src_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en_i,
    input  logic [CNT_WIDTH-1:0] x_active_i,
    input  logic [CNT_WIDTH-1:0] x_blank_i,
    input  logic [CNT_WIDTH-1:0] y_active_i,
    input  logic [CNT_WIDTH-1:0] y_blank_i,
    input  logic [1:0]           pattern_i,
    video_pattern_src_if.master  video,
    output logic [7:0]           frcnt_o,
    output logic                 busy_o,
    output logic                 cfg_err_o
);
    localparam logic [CNT_WIDTH-1:0] ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                state;
    state_t                state_next;
    geo_t                  geo;
    geo_t                  geo_in;
    geo_t                  unused_geo;
    logic                  en_q;
    logic                  load;
    logic                  cfg_err;
    logic                  frame_done;
    logic [CNT_WIDTH-1:0]  x;
    logic [CNT_WIDTH-1:0]  y;
    logic [CNT_WIDTH-1:0]  xa;
    logic [CNT_WIDTH-1:0]  xb;
    logic [CNT_WIDTH-1:0]  ya;
    logic [CNT_WIDTH-1:0]  yb;
    logic [CNT_WIDTH-1:0]  x_last;
    logic [CNT_WIDTH-1:0]  xb_last;
    logic [CNT_WIDTH-1:0]  ya_last;
    logic [CNT_WIDTH-1:0]  yb_last;
    logic [CNT_WIDTH-1:0]  line_last;
    logic [7:0]            frcnt;
    logic                  de_n;
    logic                  hs_n;
    logic                  vs_n;
    logic [DATA_WIDTH-1:0] pixel;

    always_comb begin
        geo_in          = '0;
        geo_in.x_active = GEO_WIDTH'(x_active_i);
        geo_in.x_blank  = GEO_WIDTH'(x_blank_i);
        geo_in.y_active = GEO_WIDTH'(y_active_i);
        geo_in.y_blank  = GEO_WIDTH'(y_blank_i);
        geo_in.pattern  = pattern_i;
    end

    assign unused_geo = geo;
    assign xa         = CNT_WIDTH'(geo.x_active);
    assign xb         = CNT_WIDTH'(geo.x_blank);
    assign ya         = CNT_WIDTH'(geo.y_active);
    assign yb         = CNT_WIDTH'(geo.y_blank);
    assign x_last     = xa - ONE;
    assign xb_last    = xb - ONE;
    assign ya_last    = ya - ONE;
    assign yb_last    = yb - ONE;
    assign line_last  = xa + xb - ONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A frame end with the run request still high starts the next frame with
    // freshly latched geometry, so back-to-back frames have no idle gap.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        cfg_err    = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (en_q) begin
                    if (geo_ok(geo_in)) begin
                        load       = 1'b1;
                        state_next = ACT;
                    end else begin
                        cfg_err = 1'b1;
                    end
                end
            end
            ACT: begin
                if (x == x_last) state_next = HBLK;
            end
            HBLK: begin
                if (x == xb_last) begin
                    if (y < ya_last)   state_next = ACT;
                    else if (yb != '0) state_next = VBLK;
                    else               frame_done = 1'b1;
                end
            end
            VBLK: begin
                if ((x == line_last) && (y == yb_last)) frame_done = 1'b1;
            end
            default: state_next = IDLE;
        endcase
        if (frame_done) begin
            if (en_q && geo_ok(geo_in)) begin
                load       = 1'b1;
                state_next = ACT;
            end else begin
                cfg_err    = en_q;
                state_next = IDLE;
            end
        end
    end

    always_comb begin
        de_n = (state == ACT);
        hs_n = (state == HBLK);
        vs_n = (state == ACT) || (state == HBLK);
    end

    // x counts pixels within a line in every state; y counts active lines, then
    // blank lines during vertical blanking.
    always_ff @(posedge clk) begin
        if (rst) begin
            en_q  <= 1'b0;
            geo   <= '0;
            x     <= '0;
            y     <= '0;
            frcnt <= '0;
        end else begin
            en_q <= en_i;
            if (frame_done) frcnt <= frcnt + 8'd1;
            if (load) begin
                geo <= geo_in;
                x   <= '0;
                y   <= '0;
            end else begin
                case (state)
                    ACT: begin
                        x <= (x == x_last) ? '0 : x + ONE;
                    end
                    HBLK: begin
                        if (x == xb_last) begin
                            x <= '0;
                            y <= (y < ya_last) ? y + ONE : '0;
                        end else begin
                            x <= x + ONE;
                        end
                    end
                    VBLK: begin
                        if (x == line_last) begin
                            x <= '0;
                            y <= (y == yb_last) ? '0 : y + ONE;
                        end else begin
                            x <= x + ONE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            video.de_o <= 1'b0;
            video.hs_o <= 1'b0;
            video.vs_o <= 1'b0;
            busy_o     <= 1'b0;
            cfg_err_o  <= 1'b0;
        end else begin
            video.de_o <= de_n;
            video.hs_o <= hs_n;
            video.vs_o <= vs_n;
            busy_o     <= (state_next != IDLE);
            cfg_err_o  <= cfg_err;
        end
    end

    video_pattern_px #(
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_px (
        .clk     (clk),
        .rst     (rst),
        .active  (de_n),
        .x       (x),
        .y       (y),
        .frcnt   (frcnt),
        .pattern (geo.pattern),
        .pixel   (pixel)
    );

    assign video.do_o = pixel;
    assign frcnt_o    = frcnt;

endmodule
